// File: rtl/iob2axi_rd_sched_if.sv
// Read-engine channel between the burst scheduler (master) and the AXI read engine (slave).
interface iob2axi_rd_sched_if #(
   parameter int ADDR_W = 32
);
   logic              rd_run;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_length;
   logic              rd_ready;
   logic              rd_error;

   modport master (
      output rd_run,
      output rd_addr,
      output rd_length,
      input  rd_ready,
      input  rd_error
   );

   modport slave (
      input  rd_run,
      input  rd_addr,
      input  rd_length,
      output rd_ready,
      output rd_error
   );
endinterface

// File: rtl/iob2axi_rd_sched.sv
// Splits a word-count read transfer into AXI bursts that respect MAX_BURST and 4 KB pages,
// handing each burst to the read engine and accumulating the error result.
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | validate alignment and length of the latched request
// ISSUE  | burst presented; waits for engine ready, then for it to drop (accept)
// WAIT   | engine busy with the burst; account for it when ready returns
// DONE   | one-cycle completion pulse
module iob2axi_rd_sched #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int XFER_W    = 16,
   parameter int MAX_BURST = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [ADDR_W-1:0]   base_addr_i,
   input  logic [XFER_W-1:0]   total_words_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                error_o,
   output logic [XFER_W-1:0]   burst_cnt_o,
   iob2axi_rd_sched_if.master  rd_if
);

   localparam int BYTES      = DATA_W / 8;
   localparam int LOG2_BYTES = $clog2(BYTES);
   localparam int CW         = ((XFER_W > 13) ? XFER_W : 13) + 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t              state_q,     state_d;
   logic [ADDR_W-1:0]   cur_addr_q,  cur_addr_d;
   logic [XFER_W-1:0]   remaining_q, remaining_d;
   logic                error_q,     error_d;
   logic [XFER_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic [ADDR_W-1:0]   rd_addr_q,   rd_addr_d;
   logic [7:0]          rd_length_q, rd_length_d;
   logic                issued_q,    issued_d;

   logic [8:0]          beats_cur;
   logic [ADDR_W-1:0]   burst_bytes;
   logic [XFER_W-1:0]   rem_next;

   // AXI len for the next burst: the smallest of remaining words, MAX_BURST and
   // the beats left before the next 4 KB page boundary (address is aligned here).
   function automatic logic [7:0] calc_len(input logic [11:0] page_off,
                                           input logic [XFER_W-1:0] rem);
      logic [12:0]   page_left;
      logic [CW-1:0] b;
      logic [CW-1:0] lim;
      page_left = 13'h1000 - {1'b0, page_off};
      b         = CW'(page_left >> LOG2_BYTES);
      lim       = CW'(rem);
      if (lim < b) b = lim;
      lim       = CW'(MAX_BURST);
      if (lim < b) b = lim;
      return 8'(b - CW'(1));
   endfunction

   assign beats_cur   = {1'b0, rd_length_q} + 9'd1;
   assign burst_bytes = ADDR_W'(beats_cur) << LOG2_BYTES;
   assign rem_next    = remaining_q - XFER_W'(beats_cur);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         error_q     <= 1'b0;
         burst_cnt_q <= '0;
         rd_addr_q   <= '0;
         rd_length_q <= '0;
         issued_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         error_q     <= error_d;
         burst_cnt_q <= burst_cnt_d;
         rd_addr_q   <= rd_addr_d;
         rd_length_q <= rd_length_d;
         issued_q    <= issued_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      error_d     = error_q;
      burst_cnt_d = burst_cnt_q;
      rd_addr_d   = rd_addr_q;
      rd_length_d = rd_length_q;
      issued_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               cur_addr_d  = base_addr_i;
               remaining_d = total_words_i;
               error_d     = 1'b0;
               burst_cnt_d = '0;
               state_d     = CHECK;
            end
         end
         CHECK: begin
            if ((cur_addr_q & ALIGN_MASK) != '0) begin
               error_d = 1'b1;
               state_d = DONE;
            end else if (remaining_q == '0) begin
               state_d = DONE;
            end else begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // A low rd_ready only means "accepted" once we have actually driven rd_run;
            // this keeps us from mistaking a still-busy engine (e.g. after reset) for acceptance.
            issued_d = issued_q | rd_if.rd_ready;
            if (issued_q && !rd_if.rd_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (rd_if.rd_ready) begin
               cur_addr_d  = cur_addr_q + burst_bytes;
               remaining_d = rem_next;
               burst_cnt_d = burst_cnt_q + XFER_W'(1);
               error_d     = error_q | rd_if.rd_error;
               if (rd_if.rd_error || (rem_next == '0)) begin
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_d == ISSUE) && (state_q != ISSUE)) begin
         rd_addr_d   = cur_addr_d;
         rd_length_d = calc_len(cur_addr_d[11:0], remaining_d);
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign error_o     = error_q;
   assign burst_cnt_o = burst_cnt_q;

   assign rd_if.rd_run    = (state_q == ISSUE) && rd_if.rd_ready;
   assign rd_if.rd_addr   = rd_addr_q;
   assign rd_if.rd_length = rd_length_q;

endmodule

// File: tb/tb_iob2axi_rd_sched.sv
// Directed bench for iob2axi_rd_sched: a vector table of transfers with hand-computed bursts,
// plus sequences for back-to-back start, ignored start while busy and mid-burst reset.
module tb_iob2axi_rd_sched;

   localparam int LAT = 10;
   localparam int NV  = 10;
   localparam int LOGN = 64;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base  = '0;
   logic [15:0] words = '0;
   logic        busy, done, error;
   logic [15:0] burst_cnt;

   always #5 clk = ~clk;

   iob2axi_rd_sched_if #(.ADDR_W(32)) rd_if ();

   iob2axi_rd_sched #(
      .ADDR_W(32), .DATA_W(32), .XFER_W(16), .MAX_BURST(256)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start),
      .base_addr_i   (base),
      .total_words_i (words),
      .busy_o        (busy),
      .done_o        (done),
      .error_o       (error),
      .burst_cnt_o   (burst_cnt),
      .rd_if         (rd_if)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] log_addr [LOGN];
   logic [7:0]  log_len  [LOGN];
   int          n_log  = 0;
   int          err_at = -1;

   // Read engine model: accepts rd_run, drops ready the next cycle, stays busy LAT cycles.
   initial begin
      int cnt;
      bit acc;
      cnt = 0;
      acc = 1'b0;
      rd_if.rd_ready = 1'b1;
      rd_if.rd_error = 1'b0;
      forever begin
         @(negedge clk);
         if (acc) begin
            rd_if.rd_ready = 1'b0;
            rd_if.rd_error = 1'b0;
            acc = 1'b0;
            cnt = LAT;
         end else if (!rd_if.rd_ready) begin
            if (cnt == 0) begin
               rd_if.rd_ready = 1'b1;
               rd_if.rd_error = (err_at >= 0) && (n_log - 1 == err_at);
            end else begin
               cnt--;
            end
         end else if (rd_if.rd_run) begin
            log_addr[n_log % LOGN] = rd_if.rd_addr;
            log_len[n_log % LOGN]  = rd_if.rd_length;
            n_log++;
            acc = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_done(output int cyc, output bit ok);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < 4000 && !ok; i++) begin
         @(negedge clk);
         cyc++;
         if (done) ok = 1'b1;
      end
   endtask

   task automatic launch(input logic [31:0] b, input logic [15:0] w);
      @(negedge clk);
      base  = b;
      words = w;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   typedef struct {
      logic [31:0] base;
      logic [15:0] words;
      int          err_rel;
      int          nb;
      logic        err;
      int          first;
   } vec_t;

   vec_t        vecs [NV];
   logic [31:0] ea [24];
   logic [7:0]  el [24];

   initial begin
      int  cyc;
      int  first_log;
      bit  ok;

      vecs[0] = '{32'h0000_0000, 16'd10,   -1, 1, 1'b0, 0};
      ea[0]  = 32'h0000_0000; el[0]  = 8'd9;
      vecs[1] = '{32'h0000_0000, 16'd300,  -1, 2, 1'b0, 1};
      ea[1]  = 32'h0000_0000; el[1]  = 8'd255;
      ea[2]  = 32'h0000_0400; el[2]  = 8'd43;
      vecs[2] = '{32'h0000_0FF0, 16'd8,    -1, 2, 1'b0, 3};
      ea[3]  = 32'h0000_0FF0; el[3]  = 8'd3;
      ea[4]  = 32'h0000_1000; el[4]  = 8'd3;
      vecs[3] = '{32'h0000_0000, 16'd600,   0, 1, 1'b1, 5};
      ea[5]  = 32'h0000_0000; el[5]  = 8'd255;
      vecs[4] = '{32'h0000_0002, 16'd10,   -1, 0, 1'b1, 6};
      vecs[5] = '{32'h0000_0100, 16'd0,    -1, 0, 1'b0, 6};
      vecs[6] = '{32'hFFFF_FFF8, 16'd4,    -1, 2, 1'b0, 6};
      ea[6]  = 32'hFFFF_FFF8; el[6]  = 8'd1;
      ea[7]  = 32'h0000_0000; el[7]  = 8'd1;
      vecs[7] = '{32'h0000_0800, 16'd1024, -1, 4, 1'b0, 8};
      ea[8]  = 32'h0000_0800; el[8]  = 8'd255;
      ea[9]  = 32'h0000_0C00; el[9]  = 8'd255;
      ea[10] = 32'h0000_1000; el[10] = 8'd255;
      ea[11] = 32'h0000_1400; el[11] = 8'd255;
      vecs[8] = '{32'h0000_0000, 16'd1024,  1, 2, 1'b1, 12};
      ea[12] = 32'h0000_0000; el[12] = 8'd255;
      ea[13] = 32'h0000_0400; el[13] = 8'd255;
      vecs[9] = '{32'h0000_0F00, 16'd100,  -1, 2, 1'b0, 14};
      ea[14] = 32'h0000_0F00; el[14] = 8'd63;
      ea[15] = 32'h0000_1000; el[15] = 8'd35;

      // reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst busy",      busy, 0);
      chk("rst done",      done, 0);
      chk("rst error",     error, 0);
      chk("rst burst_cnt", burst_cnt, 0);
      chk("rst rd_run",    rd_if.rd_run, 0);
      chk("rst rd_addr",   rd_if.rd_addr, 0);
      chk("rst rd_length", rd_if.rd_length, 0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         first_log = n_log;
         err_at    = (vecs[i].err_rel >= 0) ? n_log + vecs[i].err_rel : -1;
         launch(vecs[i].base, vecs[i].words);
         wait_done(cyc, ok);
         chk($sformatf("v%0d done seen", i), ok, 1);
         chk($sformatf("v%0d error", i), error, vecs[i].err);
         chk($sformatf("v%0d burst_cnt", i), burst_cnt, vecs[i].nb);
         chk($sformatf("v%0d bursts issued", i), n_log - first_log, vecs[i].nb);
         for (int j = 0; j < vecs[i].nb; j++) begin
            chk($sformatf("v%0d b%0d rd_addr", i, j), log_addr[(first_log + j) % LOGN], ea[vecs[i].first + j]);
            chk($sformatf("v%0d b%0d rd_length", i, j), log_len[(first_log + j) % LOGN], el[vecs[i].first + j]);
         end
         if (vecs[i].nb == 0) chk($sformatf("v%0d fast done", i), cyc <= 2, 1);
         @(negedge clk);
         chk($sformatf("v%0d done one cycle", i), done, 0);
         chk($sformatf("v%0d idle after done", i), busy, 0);
      end

      // back-to-back: start held through DONE is taken in the following IDLE cycle
      err_at = -1;
      launch(32'h0000_0001, 16'd4);
      wait_done(cyc, ok);
      chk("b2b first done", ok, 1);
      chk("b2b first error", error, 1);
      first_log = n_log;
      base  = 32'h0000_2000;
      words = 16'd20;
      start = 1'b1;
      @(negedge clk);
      chk("b2b idle cycle", busy, 0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b accepted", busy, 1);
      chk("b2b error cleared", error, 0);
      wait_done(cyc, ok);
      chk("b2b second done", ok, 1);
      chk("b2b burst_cnt", burst_cnt, 1);
      chk("b2b bursts issued", n_log - first_log, 1);
      chk("b2b rd_addr", log_addr[first_log % LOGN], 32'h0000_2000);
      chk("b2b rd_length", log_len[first_log % LOGN], 8'd19);

      // mid-burst reset, with an ignored start while busy
      @(negedge clk);
      err_at    = -1;
      first_log = n_log;
      launch(32'h0000_0000, 16'd300);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (n_log - first_log >= 2) ok = 1'b1;
      end
      chk("rst-seq second burst issued", ok, 1);
      @(negedge clk);
      @(negedge clk);
      base  = 32'h0000_0002;
      words = 16'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("busy start ignored busy", busy, 1);
      chk("busy start ignored error", error, 0);
      chk("busy start ignored rd_addr", rd_if.rd_addr, 32'h0000_0400);
      chk("busy burst_cnt mid", burst_cnt, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst busy",      busy, 0);
      chk("async rst done",      done, 0);
      chk("async rst error",     error, 0);
      chk("async rst burst_cnt", burst_cnt, 0);
      chk("async rst rd_run",    rd_if.rd_run, 0);
      chk("async rst rd_addr",   rd_if.rd_addr, 0);
      chk("async rst rd_length", rd_if.rd_length, 0);
      @(negedge clk);
      rst_n = 1'b1;
      first_log = n_log;
      launch(32'h0000_0040, 16'd10);
      wait_done(cyc, ok);
      chk("post-rst done", ok, 1);
      chk("post-rst error", error, 0);
      chk("post-rst burst_cnt", burst_cnt, 1);
      chk("post-rst bursts issued", n_log - first_log, 1);
      chk("post-rst rd_addr", log_addr[first_log % LOGN], 32'h0000_0040);
      chk("post-rst rd_length", log_len[first_log % LOGN], 8'd9);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
